// File: rtl/sipo_word_assembler.sv
// sipo_word_assembler: collects a serial bit stream (MSB first) into N-bit
// words. A frame starts on a qualified sync bit, may stall indefinitely on
// ser_valid=0, and is delivered as a one-cycle word_valid pulse together with
// the registered word. A sync in the middle of a frame restarts it and flags
// frame_err.
//
// Optional feature: define PARITY_CHECK_EN to append an even-parity bit to
// every frame. A good word is delivered as usual. A bad word leaves word_out
// untouched and pulses parity_err instead.
module sipo_word_assembler #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ser_valid,
  input  logic         ser_data,
  input  logic         sync,
  output logic [N-1:0] word_out,
  output logic         word_valid,
  output logic         busy,
  output logic         frame_err,
  output logic         parity_err
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t        state, state_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic [N-1:0]  word_next;
  logic [N-1:0]  shifted;
  logic          word_valid_next;
  logic          frame_err_next;
`ifdef PARITY_CHECK_EN
  logic          parity_err_next;
`endif

  // The shift register with the incoming bit appended. Earlier bits move toward the MSB.
  assign shifted = {shift_reg[N-2:0], ser_data};

  assign busy = (state != IDLE);

  // Next-state logic. A qualified sync always starts a new frame, whatever the current state.
  always_comb begin
    state_next      = state;
    bit_cnt_next    = bit_cnt;
    shift_next      = shift_reg;
    word_next       = word_out;
    word_valid_next = 1'b0;
    frame_err_next  = 1'b0;
`ifdef PARITY_CHECK_EN
    parity_err_next = 1'b0;
`endif
    if (ser_valid) begin
      if (sync) begin
        frame_err_next = (state != IDLE);
        state_next     = SHIFT;
        bit_cnt_next   = CW'(1);
        shift_next     = {{(N-1){1'b0}}, ser_data};
      end else begin
        case (state)
          IDLE: state_next = IDLE;
          SHIFT: begin
            shift_next = shifted;
            if (bit_cnt == LAST_CNT) begin
`ifdef PARITY_CHECK_EN
              state_next   = PARITY;
              bit_cnt_next = CW'(N);
`else
              state_next      = IDLE;
              bit_cnt_next    = '0;
              word_next       = shifted;
              word_valid_next = 1'b1;
`endif
            end else begin
              bit_cnt_next = bit_cnt + CW'(1);
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            state_next   = IDLE;
            bit_cnt_next = '0;
            if (^{shift_reg, ser_data}) begin
              parity_err_next = 1'b1;
            end else begin
              word_next       = shift_reg;
              word_valid_next = 1'b1;
            end
          end
`endif
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // State, datapath and output pulse registers. Reset discards any partial frame without a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt_next;
      shift_reg  <= shift_next;
      word_out   <= word_next;
      word_valid <= word_valid_next;
      frame_err  <= frame_err_next;
`ifdef PARITY_CHECK_EN
      parity_err <= parity_err_next;
`endif
    end
  end

`ifndef PARITY_CHECK_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_assembler.sv
// tb_sipo_word_assembler: frame-level stimulus with a scoreboard. Every frame
// issued pushes the pulse it must produce: a word, a frame error or a parity
// error. An independent monitor pops and compares on each output pulse. It
// also checks that word_out never changes without a pulse.
module tb_sipo_word_assembler;

  localparam int N = 8;
`ifdef PARITY_CHECK_EN
  localparam int FULL = N + 1;
`else
  localparam int FULL = N;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         ser_valid;
  logic         ser_data;
  logic         sync;
  logic [N-1:0] word_out;
  logic         word_valid;
  logic         busy;
  logic         frame_err;
  logic         parity_err;

  typedef enum int {EV_WORD = 1, EV_FRAME_ERR = 2, EV_PARITY_ERR = 3} ev_kind_t;
  typedef struct {
    ev_kind_t     kind;
    logic [N-1:0] word;
  } ev_t;

  ev_t          exp_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [N-1:0] exp_word = '0;
  bit           in_frame = 1'b0;
  int           cycle = 0;
  int           last_wv = -1;
  int           prev_wv = -1;

  sipo_word_assembler #(.N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .sync       (sync),
    .word_out   (word_out),
    .word_valid (word_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to measure the spacing between word pulses
  always @(posedge clk) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushEvent(input ev_kind_t kind, input logic [N-1:0] word);
    ev_t e;
    e.kind = kind;
    e.word = word;
    exp_q.push_back(e);
  endtask

  task automatic popCheck(input ev_kind_t kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_pulse", kind, 0);
    end else begin
      e = exp_q.pop_front();
      checkOutput("pulse_kind", kind, e.kind);
      if (e.kind == EV_WORD && kind == EV_WORD) begin
        checkOutput("word_out", word_out, e.word);
        exp_word = e.word;
        prev_wv  = last_wv;
        last_wv  = cycle;
      end
    end
  endtask

  // Monitor: consume each pulse seen on the falling edge and check word_out holds between pulses
  always @(negedge clk) begin
    if (reset_n) begin
      if (word_valid) popCheck(EV_WORD);
      if (frame_err)  popCheck(EV_FRAME_ERR);
      if (parity_err) popCheck(EV_PARITY_ERR);
      checkOutput("word_out_hold", word_out, exp_word);
    end
  end

  task automatic drive(input logic v, input logic s, input logic d);
    ser_valid = v;
    sync      = s;
    ser_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic stallCycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic idleNoise(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'($urandom));
  endtask

  // Send the first nbits of a frame (data MSB first, then parity if enabled) and record the expected outcome
  task automatic applyStimulus(input logic [N-1:0] word, input int nbits, input int stall_at,
                               input int stall_len, input bit rand_stall, input bit par_flip);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) stallCycles(stall_len);
      if (rand_stall && i > 0 && $urandom_range(3) == 0) stallCycles($urandom_range(3, 1));
      if (i == 0 && in_frame) pushEvent(EV_FRAME_ERR, '0);
      if (i == 0) in_frame = 1'b1;
      b = (i < N) ? word[N-1-i] : ((^word) ^ par_flip);
      if (i == FULL - 1) begin
`ifdef PARITY_CHECK_EN
        if (par_flip) pushEvent(EV_PARITY_ERR, '0);
        else          pushEvent(EV_WORD, word);
`else
        pushEvent(EV_WORD, word);
`endif
      end
      drive(1'b1, (i == 0), b);
      if (i == 0) checkOutput("busy_started", busy, 1);
    end
    ser_valid = 1'b0;
    if (nbits == FULL) begin
      in_frame = 1'b0;
      checkOutput("busy_done", busy, 0);
    end else begin
      checkOutput("busy_partial", busy, 1);
    end
  endtask

  // Assert reset mid-stream once any pending pulse has been seen, then check that every output is forced low
  task automatic doReset();
    @(negedge clk);
    #1;
    reset_n   = 1'b0;
    exp_word  = '0;
    ser_valid = 1'b1;
    sync      = 1'b1;
    ser_data  = 1'b1;
    #1;
    checkOutput("rst_word_out", word_out, 0);
    checkOutput("rst_word_valid", word_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_parity_err", parity_err, 0);
    @(posedge clk);
    #1;
    checkOutput("rst_busy_held", busy, 0);
    checkOutput("rst_word_held", word_out, 0);
    ser_valid = 1'b0;
    sync      = 1'b0;
    reset_n   = 1'b1;
    in_frame  = 1'b0;
    checkOutput("queue_empty_after_reset", exp_q.size(), 0);
  endtask

  // Directed scenarios first, then randomized frames
  initial begin
    reset_n   = 1'b0;
    ser_valid = 1'b0;
    sync      = 1'b0;
    ser_data  = 1'b0;
    #2;
    checkOutput("init_word_out", word_out, 0);
    checkOutput("init_word_valid", word_valid, 0);
    checkOutput("init_busy", busy, 0);
    checkOutput("init_frame_err", frame_err, 0);
    checkOutput("init_parity_err", parity_err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Valid bits without sync after reset must be ignored
    idleNoise(4);
    checkOutput("busy_after_noise", busy, 0);

    applyStimulus(8'hA5, FULL, -1, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    applyStimulus(8'hA5, FULL, 4, 3, 1'b0, 1'b0);

    applyStimulus(8'h5A, 3, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h3C, FULL, -1, 0, 1'b0, 1'b0);

    applyStimulus(8'hFF, FULL, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h00, FULL, -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("b2b_spacing", last_wv - prev_wv, FULL);
    checkOutput("b2b_last_word", word_out, 8'h00);

    applyStimulus(8'hC3, 5, -1, 0, 1'b0, 1'b0);
    doReset();
    idleNoise(3);
    applyStimulus(8'h81, FULL, -1, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    checkOutput("after_reset_word", word_out, 8'h81);

`ifdef PARITY_CHECK_EN
    applyStimulus(8'hA5, FULL, -1, 0, 1'b0, 1'b0);
    applyStimulus(8'h01, FULL, -1, 0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("parity_word_kept", word_out, 8'hA5);
`endif

    for (int it = 0; it < 200; it++) begin
      int sel;
      logic [N-1:0] w;
      sel = $urandom_range(99);
      w   = N'($urandom);
      if (sel < 65) begin
        applyStimulus(w, FULL, -1, 0, 1'b1, ($urandom_range(3) == 0));
      end else if (sel < 82) begin
        applyStimulus(w, $urandom_range(FULL - 1, 1), -1, 0, 1'b1, 1'b0);
      end else if (sel < 94) begin
        if (!in_frame) idleNoise($urandom_range(4, 1));
        else stallCycles(2);
      end else begin
        doReset();
      end
    end

    repeat (3) drive(1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
